// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display controller: hex or decimal (double-dabble) loading,
// leading-zero blanking, per-digit decimal points and a free-running digit scan.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data,
    input  logic              data_en,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] led_en,
    output logic [7:0]        led_cx,
    output logic              busy
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned BcdW = 40;

    typedef enum logic {StIdle, StConv} state_e;

    state_e              state_q, state_d;
    logic [DIGITS*4-1:0] disp_q, disp_d;
    logic [31:0]         shift_q, shift_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                started_q, started_d;
    logic [DIGITS-1:0]   led_en_q, led_en_d;

    logic [BcdW-1:0]     bcd_adj, bcd_next;
    logic [3:0]          cur_digit;
    logic                nz_above;
    logic                blank;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        unique case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0011000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b0100111;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            disp_q     <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            led_en_q   <= '1;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            led_en_q   <= led_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (data_en && mode) state_d = StConv;
            StConv:  if (bit_cnt_q == 5'd31) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StConv);
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < BcdW / 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BcdW-2:0], shift_q[31]};
    end

    always_comb begin
        disp_d    = disp_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (data_en) begin
                    if (mode) begin
                        shift_d   = data;
                        bcd_d     = '0;
                        bit_cnt_d = '0;
                    end else begin
                        disp_d = data[DIGITS*4-1:0];
                    end
                end
            end
            StConv: begin
                shift_d   = shift_q << 1;
                bcd_d     = bcd_next;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) disp_d = bcd_next[DIGITS*4-1:0];
            end
            default: ;
        endcase
    end

    // The first post-reset cycle only lights digit 0; counting starts after it so
    // every digit, including the first, stays lit for SCAN_DIV cycles.
    always_comb begin
        started_d  = 1'b1;
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (started_q) begin
            if (scan_cnt_q == CntW'(SCAN_DIV - 1)) begin
                scan_cnt_d = '0;
                idx_d      = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
        led_en_d = ~(DIGITS'(1) << idx_d);
    end

    always_comb begin
        cur_digit = disp_q[idx_q*4 +: 4];
        nz_above  = 1'b0;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (j >= int'(idx_q) && disp_q[j*4 +: 4] != 4'h0) nz_above = 1'b1;
        end
        blank = blank_lz && (idx_q != '0) && !nz_above;
        if (&led_en_q) begin
            led_cx = 8'hFF;
        end else begin
            led_cx = {~dp_mask[idx_q], blank ? 7'h7F : glyph(cur_digit)};
        end
    end

    assign led_en = led_en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: table of load vectors checked through a
// scoreboard over one full scan rotation, plus reset, ignore-while-busy and abort sequences.
module tb_seg7_scan_ctrl;
    localparam int Digits  = 8;
    localparam int ScanDiv = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic        data_en = 1'b0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;
    logic        busy;
    logic [0:0]  led_en1;
    logic [7:0]  led_cx1;
    logic        busy1;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(Digits), .SCAN_DIV(ScanDiv)) dut (
        .clk(clk), .rst(rst), .data(data), .data_en(data_en), .mode(mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .led_en(led_en), .led_cx(led_cx), .busy(busy)
    );

    seg7_scan_ctrl #(.DIGITS(1), .SCAN_DIV(2)) dut1 (
        .clk(clk), .rst(rst), .data(data), .data_en(data_en), .mode(mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask[0:0]), .led_en(led_en1), .led_cx(led_cx1),
        .busy(busy1)
    );

    typedef struct {
        logic            m;
        logic [31:0]     d;
        logic            bl;
        logic [7:0]      dp;
        logic            fixed;
        logic [7:0][7:0] exp;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [6:0] glyph_tab [16];
    logic [3:0] cur [8];
    logic [7:0] sbq [$];
    vec_t       vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_cx(input int i);
        logic hi;
        logic [7:0] r;
        hi = 1'b0;
        for (int j = i; j < Digits; j++) if (cur[j] != 4'h0) hi = 1'b1;
        r[7]   = ~dp_mask[i];
        r[6:0] = (blank_lz && i > 0 && !hi) ? 7'h7F : glyph_tab[cur[i]];
        return r;
    endfunction

    function automatic int cur_idx();
        int k;
        k = 0;
        for (int i = 0; i < Digits; i++) if (!led_en[i]) k = i;
        return k;
    endfunction

    task automatic set_digits(input logic m, input logic [31:0] d);
        logic [31:0] v;
        v = d;
        for (int i = 0; i < Digits; i++) begin
            if (!m) begin
                cur[i] = d[4*i +: 4];
            end else begin
                cur[i] = 4'(v % 10);
                v      = v / 10;
            end
        end
    endtask

    // Drive one load; for decimal loads, check the old value is held while busy and
    // optionally poke a stray data_en at busy cycle poke_at.
    task automatic load(input logic m, input logic [31:0] d, input logic bl,
                        input logic [7:0] dp, input int poke_at, input string name);
        int bcnt;
        @(negedge clk);
        mode = m; data = d; blank_lz = bl; dp_mask = dp; data_en = 1'b1;
        @(negedge clk);
        data_en = 1'b0;
        if (m) begin
            bcnt = 0;
            while (busy && bcnt < 40) begin
                check({name, "_held"}, led_cx, model_cx(cur_idx()));
                data_en = (bcnt == poke_at);
                if (bcnt == poke_at) begin
                    data = 32'h0;
                    mode = 1'b0;
                end
                bcnt++;
                @(negedge clk);
            end
            data_en = 1'b0;
            check({name, "_busy_cycles"}, bcnt, 32);
        end else begin
            check({name, "_busy"}, busy, 1'b0);
        end
        set_digits(m, d);
        check({name, "_now"}, led_cx, model_cx(cur_idx()));
    endtask

    task automatic observe(input string name);
        logic [7:0] obs [8];
        int zeros;
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int i = 0; i < Digits; i++) obs[i] = 8'hxx;
        for (int c = 0; c < Digits * ScanDiv; c++) begin
            zeros = 0;
            for (int k = 0; k < Digits; k++) if (!led_en[k]) zeros++;
            if (zeros != 1) bad++;
            else obs[cur_idx()] = led_cx;
            @(negedge clk);
        end
        check({name, "_onehot"}, bad, 0);
        for (int i = 0; i < Digits; i++) begin
            e = sbq.pop_front();
            check($sformatf("%s_digit%0d", name, i), obs[i], e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                      7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0] = '{1'b0, 32'h1234ABCD, 1'b0, 8'h00, 1'b1,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hA7, 8'hA1}};
        vecs[1] = '{1'b1, 32'd12345678, 1'b0, 8'h00, 1'b1,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}};
        vecs[2] = '{1'b0, 32'h00000A05, 1'b1, 8'h04, 1'b1,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hC0, 8'h92}};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 8'h00, 1'b1,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[4] = '{1'b1, 32'd100, 1'b1, 8'h01, 1'b1,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'h40}};
        vecs[5] = '{1'b0, 32'hFEDCBA98, 1'b0, 8'hFF, 1'b0, '0};
        vecs[6] = '{1'b1, 32'd3000000000, 1'b1, 8'h00, 1'b0, '0};
        vecs[7] = '{1'b1, 32'd0, 1'b0, 8'h80, 1'b0, '0};
        for (int i = 0; i < Digits; i++) cur[i] = 4'h0;

        // Reset and scan rotation
        repeat (2) @(negedge clk);
        check("rst_led_en", led_en, 8'hFF);
        check("rst_led_cx", led_cx, 8'hFF);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("scan_first", led_en, 8'hFE);
        check("scan_first_cx", led_cx, 8'hC0);
        repeat (3) @(negedge clk);
        check("scan_hold4", led_en, 8'hFE);
        @(negedge clk);
        check("scan_step", led_en, 8'hFD);
        repeat (28) @(negedge clk);
        check("scan_wrap", led_en, 8'hFE);

        // Table-driven loads
        for (int v = 0; v < 8; v++) begin
            load(vecs[v].m, vecs[v].d, vecs[v].bl, vecs[v].dp, -1, $sformatf("vec%0d", v));
            for (int i = 0; i < Digits; i++)
                sbq.push_back(vecs[v].fixed ? vecs[v].exp[i] : model_cx(i));
            observe($sformatf("vec%0d", v));
        end

        // All-ones decimal with a stray load strobe mid-conversion
        load(1'b1, 32'hFFFFFFFF, 1'b0, 8'h00, 10, "ffff");
        for (int i = 0; i < Digits; i++) sbq.push_back(model_cx(i));
        check("ffff_digit7_const", model_cx(7), 8'h98);
        observe("ffff");
        check("ffff_idle_after", busy, 1'b0);

        // Reset in the middle of a conversion
        @(negedge clk);
        blank_lz = 1'b0; dp_mask = 8'h00; mode = 1'b1; data = 32'd12345678; data_en = 1'b1;
        @(negedge clk);
        data_en = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_led_en", led_en, 8'hFF);
        check("abort_led_cx", led_cx, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < Digits; i++) cur[i] = 4'h0;
        @(negedge clk);
        check("abort_release_en", led_en, 8'hFE);
        check("abort_release_cx", led_cx, 8'hC0);
        for (int i = 0; i < Digits; i++) sbq.push_back(model_cx(i));
        observe("abort");
        check("abort_busy_after", busy, 1'b0);

        // Single-digit instance never moves its enable
        check("one_digit_en", led_en1, 1'b0);
        check("one_digit_cx", led_cx1, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
